// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Turns a stream of symbolic operations (op kind, rd, rs1, rs2, imm) into
//   RV32I instruction words and writes them to consecutive instruction-memory
//   word addresses through a request/acknowledge handshake. The boot/test
//   loader uses it to place a program before the core leaves reset.
//
// Parameters
//   ADDR_WIDTH  word-address width; memory holds 2**ADDR_WIDTH words
//   BASE_ADDR   first word address written after start
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   start                begins a load session when idle
//   in_valid / in_ready  operation handshake
//   in_op, in_rd, in_rs1, in_rs2, in_imm, in_last   operation fields
//   mem_we / mem_ack     write request (held until acknowledged)
//   mem_addr, mem_wdata  word address and encoded instruction
//   busy, done, full     status: not idle, end-of-session pulse, capacity hit
//   count                words written in the current session
//   op_err               sticky reserved-op flag (only with the macro below)
//
// Build option
//   INSTR_ENCODER_OP_CHECK_EN  reserved ops (6/7) are consumed without a
//                              write and raise op_err; otherwise they are
//                              written as NOP (0x00000013).
module instr_encoder_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [11:0]           in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
`ifdef INSTR_ENCODER_OP_CHECK_EN
  ,
  output logic                  op_err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  last_q,  last_d;
  logic                  full_q,  full_d;
  logic [31:0]           enc;
`ifdef INSTR_ENCODER_OP_CHECK_EN
  logic                  err_q,   err_d;
  logic                  reserved;
  assign reserved = (in_op[2:1] == 2'b11);
  assign op_err   = err_q;
`endif

  // Field packing per op kind; BEQ's in_imm already holds offset[12:1].
  always_comb begin
    enc = 32'h0000_0013;
    case (in_op)
      3'd0: enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      3'd1: enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      3'd2: enc = {in_imm, in_rs1, 3'b000, in_rd, 7'b0010011};
      3'd3: enc = {in_imm, in_rs1, 3'b010, in_rd, 7'b0000011};
      3'd4: enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      3'd5: enc = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, 3'b000,
                   in_imm[3:0], in_imm[10], 7'b1100011};
      default: enc = 32'h0000_0013;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    last_d  = last_q;
    full_d  = full_q;
`ifdef INSTR_ENCODER_OP_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = BASE;
          count_d = '0;
          full_d  = 1'b0;
`ifdef INSTR_ENCODER_OP_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (in_valid) begin
`ifdef INSTR_ENCODER_OP_CHECK_EN
          if (reserved) begin
            // Consumed without a write; a reserved last op still ends the session.
            err_d = 1'b1;
            if (in_last) state_d = S_DONE;
          end else begin
            wdata_d = enc;
            last_d  = in_last;
            state_d = S_WRITE;
          end
`else
          wdata_d = enc;
          last_d  = in_last;
          state_d = S_WRITE;
`endif
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          count_d = count_q + (ADDR_WIDTH+1)'(1);
          addr_d  = addr_q + ADDR_WIDTH'(1);
          // Top word written: stop here so the address never wraps into a rewrite.
          if (addr_q == ADDR_MAX) full_d = 1'b1;
          state_d = (last_q || (addr_q == ADDR_MAX)) ? S_DONE : S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      wdata_q <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      full_q  <= 1'b0;
`ifdef INSTR_ENCODER_OP_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      last_q  <= last_d;
      full_q  <= full_d;
`ifdef INSTR_ENCODER_OP_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign mem_we    = (state_q == S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign full      = full_q;
  assign count     = count_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decode path: accepts symbolic operations (op kind, register indices, immediate) over a valid/ready stream.
- Encodes each operation into a 32-bit RV32I instruction word.
- Writes the words sequentially into instruction memory through a write-request/acknowledge handshake.
- Used by the boot/test loader to place programs in instruction memory before the core leaves reset.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory; capacity 2**ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  pulse in IDLE begins a load session; ignored elsewhere.
- in_valid  input  1  operation available.
- in_ready  output  1  encoder accepts operation this cycle.
- in_op  input  3  0=ADD 1=SUB 2=ADDI 3=LW 4=SW 5=BEQ 6/7=reserved.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_imm  input  12  immediate; for BEQ holds offset bits [12:1].
- in_last  input  1  final operation of the session.
- mem_we  output  1  write request, held until acknowledged.
- mem_addr  output  ADDR_WIDTH  word address.
- mem_wdata  output  32  encoded instruction.
- mem_ack  input  1  memory accepted the write this cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at session end.
- full  output  1  session ended because memory capacity was reached; sticky until next start.
- count  output  ADDR_WIDTH+1  words written in the current session.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, full=0, count=0. Reset mid-session abandons it; no partial write remains asserted.
- Field mapping; all encodings are registered:
  - ADD: funct7=0000000, f3=000, opcode 0110011.
  - SUB: funct7=0100000, f3=000, opcode 0110011.
  - ADDI: {imm,rs1,000,rd,0010011}.
  - LW: {imm,rs1,010,rd,0000011}.
  - SW: {imm[11:5],rs2,rs1,010,imm[4:0],0100011}.
  - BEQ, with o=in_imm representing offset[12:1]: {o[11],o[9:4],rs2,rs1,000,o[3:0],o[10],1100011}.
- FSM:
  - IDLE: in_ready=0. start → LOAD; mem_addr←BASE_ADDR, count←0, full←0.
  - LOAD: in_ready=1. On in_valid&in_ready: mem_wdata←encoded word, last flag captured → WRITE.
  - WRITE: mem_we=1, in_ready=0; mem_addr and mem_wdata stable. On mem_ack: count+1, mem_addr+1.
    - If captured last → DONE.
    - Else if mem_addr was 2**ADDR_WIDTH-1 → full←1, DONE.
    - Else → LOAD.
    - No wrap-around write occurs.
  - DONE: done=1 for exactly one cycle → IDLE.
- Latency: accept → mem_we asserted next cycle; minimum 2 cycles per word (mem_ack same cycle as first mem_we).
- mem_ack outside WRITE is ignored. start while busy is ignored.
- in_valid with in_last on the capacity word: DONE with full=1.

Optional Feature:
- Macro: INSTR_ENCODER_OP_CHECK_EN.
- Defined:
  - Reserved in_op (6/7) is consumed (handshake completes) but not written; state stays in LOAD.
  - Sticky output op_err (1 bit, reset 0, cleared on start) is set.
  - If the reserved op carries in_last, → DONE with no write.
- Undefined:
  - Reserved in_op encodes as NOP 0x00000013 and is written normally.
  - No op_err port exists.

Test Plan:
- After reset: all outputs at reset values; start, then ADD rd=3 rs1=1 rs2=2 with in_last=1, mem_ack tied 1 → mem_wdata=0x002081B3 at addr 0, done pulse, count=1.
- Session SUB x5,x6,x7; ADDI x1,x0,imm=0xFFF; SW rs2=2 rs1=1 imm=8; BEQ rs1=1 rs2=2 in_imm=0x004 (last):
  - Writes 0x407302B3, 0xFFF00093, 0x0020A423, 0x00208463 to addrs 0..3.
  - count=4.
- mem_ack delayed 3 cycles per write with in_valid held high: in_ready stays 0 and mem_addr/mem_wdata are stable through WRITE; no operation is lost or duplicated.
- ADDR_WIDTH=2, feed 6 ops with no in_last:
  - 4 writes to addrs 0..3, then done and full=1.
  - in_ready=0 afterwards.
  - Next start clears full.
- Assert rst during WRITE of the 2nd word → mem_we drops immediately, state IDLE, count=0; a new session rewrites from BASE_ADDR.
- Reserved op 7 mid-session:
  - With the macro: no write, op_err=1, following op written to the next address.
  - Without the macro: 0x00000013 written.
